// File: rtl/branch_resolver.sv
// Execute-stage branch resolution: turns comparator result + prediction into a front-end redirect and flush.
// Latency: mispredict resolved in cycle N raises redirect_valid in N+1; execute reopens DRAIN_CYCLES+1 cycles after fetch accepts.
// Backpressure: redirect held stable until fetch_ready; ex_accept drops while redirecting/draining so upstream holds.
module branch_resolver #(
    parameter int unsigned DRAIN_CYCLES = 1,
    parameter int unsigned COUNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ex_valid,
    input  logic                   is_branch,
    input  logic                   is_jump,
    input  logic                   cmp_out,
    input  logic                   invert,
    input  logic                   predicted_taken,
    input  logic [31:0]            pc,
    input  logic [31:0]            target,
    input  logic                   fetch_ready,
    output logic                   ex_accept,
    output logic                   redirect_valid,
    output logic [31:0]            redirect_pc,
    output logic                   flush,
    output logic                   misaligned_fault,
    output logic [COUNT_WIDTH-1:0] branch_count,
    output logic [COUNT_WIDTH-1:0] mispredict_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2
    } state_t;

    localparam logic [3:0]             DRAIN_LOAD = 4'(DRAIN_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE    = COUNT_WIDTH'(1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  drain_cnt;
    logic [3:0]  drain_cnt_nxt;

    logic        taken;
    logic        resolving;
    logic        mispredict;
    logic        fault;
    logic        start_redirect;
    logic [31:0] correct_pc;

    // Branch outcome; cmp_out is only looked at for conditional branches so an X there cannot leak.
    always_comb begin
        taken = 1'b0;
        if (is_jump) begin
            taken = 1'b1;
        end else if (is_branch) begin
            taken = cmp_out ^ invert;
        end
    end

    assign resolving      = ex_valid & ex_accept & (is_branch | is_jump);
    assign mispredict     = taken != predicted_taken;
    assign fault          = resolving & taken & (target[1:0] != 2'b00);
    assign start_redirect = resolving & mispredict & ~fault;
    assign correct_pc     = taken ? target : pc + 32'd4;

    // Recovery FSM next-state and handshake outputs.
    always_comb begin
        state_nxt      = state;
        drain_cnt_nxt  = drain_cnt;
        ex_accept      = 1'b0;
        redirect_valid = 1'b0;
        flush          = 1'b0;
        case (state)
            IDLE: begin
                ex_accept = 1'b1;
                if (start_redirect) begin
                    state_nxt = REDIRECT;
                end
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                flush          = 1'b1;
                if (fetch_ready) begin
                    if (DRAIN_LOAD == 4'd0) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt     = DRAIN;
                        drain_cnt_nxt = DRAIN_LOAD;
                    end
                end
            end
            DRAIN: begin
                flush = 1'b1;
                if (drain_cnt <= 4'd1) begin
                    state_nxt     = IDLE;
                    drain_cnt_nxt = 4'd0;
                end else begin
                    drain_cnt_nxt = drain_cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM state and drain counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            drain_cnt <= 4'd0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    // Redirect target capture (held while waiting for fetch) and one-cycle fault pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            redirect_pc      <= 32'd0;
            misaligned_fault <= 1'b0;
        end else begin
            if (start_redirect) begin
                redirect_pc <= correct_pc;
            end
            misaligned_fault <= fault;
        end
    end

    // Saturating trace counters; mispredicts count only when a redirect is actually launched.
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (resolving && branch_count != CNT_MAX) begin
                branch_count <= branch_count + CNT_ONE;
            end
            if (start_redirect && mispredict_count != CNT_MAX) begin
                mispredict_count <= mispredict_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed scenarios plus randomized traffic against a behavioural model.
// Latency: inputs driven on negedge, outputs sampled on the following negedge.
// Backpressure: fetch_ready held low or randomized to exercise redirect hold.
module tb_branch_resolver;

    localparam int DRAIN = 1;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          ex_valid;
    logic          is_branch;
    logic          is_jump;
    logic          cmp_out;
    logic          invert;
    logic          predicted_taken;
    logic [31:0]   pc;
    logic [31:0]   target;
    logic          fetch_ready;
    logic          ex_accept;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          flush;
    logic          misaligned_fault;
    logic [CW-1:0] branch_count;
    logic [CW-1:0] mispredict_count;

    int checks = 0;
    int fails  = 0;

    // Behavioural model: pending redirect, remaining flush cycles, counters.
    bit          m_rv;
    logic [31:0] m_rpc;
    int          m_drain;
    bit          m_fault;
    int          m_bc;
    int          m_mc;

    branch_resolver #(.DRAIN_CYCLES(DRAIN), .COUNT_WIDTH(CW)) dut (
        .clk              (clk),
        .reset            (reset),
        .ex_valid         (ex_valid),
        .is_branch        (is_branch),
        .is_jump          (is_jump),
        .cmp_out          (cmp_out),
        .invert           (invert),
        .predicted_taken  (predicted_taken),
        .pc               (pc),
        .target           (target),
        .fetch_ready      (fetch_ready),
        .ex_accept        (ex_accept),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .flush            (flush),
        .misaligned_fault (misaligned_fault),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        bit accept;
        bit tk;
        bit nf;
        nf = 1'b0;
        if (reset) begin
            m_rv = 0; m_rpc = 32'd0; m_drain = 0; m_bc = 0; m_mc = 0;
        end else begin
            accept = !m_rv && (m_drain == 0);
            if (accept && ex_valid && (is_branch || is_jump)) begin
                tk = is_jump ? 1'b1 : (cmp_out ^ invert);
                if (m_bc < CMAX) m_bc++;
                if (tk && (target % 4 != 0)) begin
                    nf = 1'b1;
                end else if (tk != predicted_taken) begin
                    m_rv  = 1'b1;
                    m_rpc = tk ? target : pc + 32'd4;
                    if (m_mc < CMAX) m_mc++;
                end
            end else if (m_rv && fetch_ready) begin
                m_rv    = 1'b0;
                m_drain = DRAIN;
            end else if (m_drain > 0) begin
                m_drain--;
            end
        end
        m_fault = nf;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input bit br, input bit jmp, input bit cmp, input bit inv,
                         input bit pred, input logic [31:0] p, input logic [31:0] t);
        ex_valid = v; is_branch = br; is_jump = jmp; cmp_out = br ? cmp : 1'bx;
        invert = inv; predicted_taken = pred; pc = p; target = t;
    endtask

    task automatic idle_in();
        ex_valid = 1'b0; is_branch = 1'b0; is_jump = 1'b0; cmp_out = 1'bx;
    endtask

    task automatic test_reset();
        reset = 1'b1; fetch_ready = 1'b0; invert = 1'b0; predicted_taken = 1'b0;
        pc = 32'd0; target = 32'd0; idle_in();
        tick(); tick();
        reset = 1'b0;
        checks++;
        if ({redirect_valid, flush, misaligned_fault, ex_accept} !== 4'b0001) begin
            fails++; $display("FAIL reset_ctrl: got rv/fl/flt/acc=%b want 0001",
                              {redirect_valid, flush, misaligned_fault, ex_accept});
        end
        checks++;
        if ({redirect_pc, branch_count, mispredict_count} !== '0) begin
            fails++; $display("FAIL reset_regs: got rpc=%h bc=%0d mc=%0d want 0", redirect_pc,
                              branch_count, mispredict_count);
        end
    endtask

    task automatic test_beq_mispredict();
        drive(1, 1, 0, 1, 0, 0, 32'h100, 32'h140);
        tick(); idle_in();
        checks++;
        if ({redirect_valid, flush, ex_accept} !== 3'b110 || redirect_pc !== 32'h140) begin
            fails++; $display("FAIL beq_redirect: got rv/fl/acc=%b rpc=%h want 110 rpc=00000140",
                              {redirect_valid, flush, ex_accept}, redirect_pc);
        end
        checks++;
        if (mispredict_count !== 4'd1 || branch_count !== 4'd1) begin
            fails++; $display("FAIL beq_counts: got mc=%0d bc=%0d want 1 1", mispredict_count, branch_count);
        end
        fetch_ready = 1'b1; tick(); fetch_ready = 1'b0;
        checks++;
        if ({redirect_valid, flush, ex_accept} !== 3'b010) begin
            fails++; $display("FAIL beq_drain: got rv/fl/acc=%b want 010", {redirect_valid, flush, ex_accept});
        end
        tick();
        checks++;
        if ({redirect_valid, flush, ex_accept} !== 3'b001) begin
            fails++; $display("FAIL beq_recover: got rv/fl/acc=%b want 001", {redirect_valid, flush, ex_accept});
        end
    endtask

    task automatic test_bne_hold();
        drive(1, 1, 0, 1, 1, 1, 32'h200, 32'h280);
        tick();
        // Upstream presents another jump while stalled; it must be ignored.
        drive(1, 0, 1, 0, 0, 0, 32'h500, 32'h300);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (redirect_valid !== 1'b1 || redirect_pc !== 32'h204 || ex_accept !== 1'b0 ||
                branch_count !== 4'd2) begin
                fails++; $display("FAIL bne_hold[%0d]: got rv=%b rpc=%h acc=%b bc=%0d want 1 00000204 0 2",
                                  i, redirect_valid, redirect_pc, ex_accept, branch_count);
            end
            if (i < 3) tick();
        end
        idle_in(); fetch_ready = 1'b1; tick(); fetch_ready = 1'b0;
        checks++;
        if ({redirect_valid, flush, ex_accept} !== 3'b010) begin
            fails++; $display("FAIL bne_drain: got rv/fl/acc=%b want 010", {redirect_valid, flush, ex_accept});
        end
        tick();
        checks++;
        if ({redirect_valid, flush, ex_accept} !== 3'b001 || mispredict_count !== 4'd2) begin
            fails++; $display("FAIL bne_recover: got rv/fl/acc=%b mc=%0d want 001 2",
                              {redirect_valid, flush, ex_accept}, mispredict_count);
        end
    endtask

    task automatic test_correct_pred();
        drive(1, 0, 1, 0, 0, 1, 32'h300, 32'h400);
        tick(); idle_in();
        checks++;
        if ({redirect_valid, flush, ex_accept, misaligned_fault} !== 4'b0010 ||
            branch_count !== 4'd3 || mispredict_count !== 4'd2) begin
            fails++; $display("FAIL correct_pred: got rv/fl/acc/flt=%b bc=%0d mc=%0d want 0010 3 2",
                              {redirect_valid, flush, ex_accept, misaligned_fault}, branch_count, mispredict_count);
        end
    endtask

    task automatic test_misaligned();
        drive(1, 0, 1, 0, 0, 0, 32'h310, 32'h402);
        tick(); idle_in();
        checks++;
        if ({misaligned_fault, redirect_valid, flush} !== 3'b100 ||
            mispredict_count !== 4'd2 || branch_count !== 4'd4) begin
            fails++; $display("FAIL misaligned: got flt/rv/fl=%b mc=%0d bc=%0d want 100 2 4",
                              {misaligned_fault, redirect_valid, flush}, mispredict_count, branch_count);
        end
        tick();
        checks++;
        if ({misaligned_fault, redirect_valid} !== 2'b00) begin
            fails++; $display("FAIL misaligned_pulse: got flt/rv=%b want 00", {misaligned_fault, redirect_valid});
        end
    endtask

    task automatic test_pc_wrap();
        drive(1, 1, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h0000_0040);
        tick(); idle_in();
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0) begin
            fails++; $display("FAIL pc_wrap: got rv=%b rpc=%h want 1 00000000", redirect_valid, redirect_pc);
        end
        fetch_ready = 1'b1; tick(); fetch_ready = 1'b0; tick();
    endtask

    task automatic test_saturation();
        // 20 back-to-back mispredicting jumps, each: resolve, redirect (accepted at once), drain.
        drive(1, 0, 1, 0, 0, 0, 32'h600, 32'h700);
        fetch_ready = 1'b1;
        repeat (60) tick();
        idle_in(); fetch_ready = 1'b0; tick();
        checks++;
        if (mispredict_count !== 4'(CMAX) || branch_count !== 4'(CMAX)) begin
            fails++; $display("FAIL saturation: got mc=%0d bc=%0d want %0d %0d",
                              mispredict_count, branch_count, CMAX, CMAX);
        end
    endtask

    task automatic test_reset_mid_redirect();
        drive(1, 1, 0, 1, 0, 0, 32'h800, 32'h900);
        tick(); idle_in();
        checks++;
        if (redirect_valid !== 1'b1) begin
            fails++; $display("FAIL rst_mid_setup: got rv=%b want 1", redirect_valid);
        end
        reset = 1'b1; tick(); reset = 1'b0;
        checks++;
        if ({redirect_valid, flush, ex_accept} !== 3'b001 || redirect_pc !== 32'h0 ||
            branch_count !== 4'd0 || mispredict_count !== 4'd0) begin
            fails++; $display("FAIL rst_mid: got rv/fl/acc=%b rpc=%h bc=%0d mc=%0d want 001 0 0 0",
                              {redirect_valid, flush, ex_accept}, redirect_pc, branch_count, mispredict_count);
        end
    endtask

    task automatic test_random();
        int kind;
        for (int n = 0; n < 400; n++) begin
            reset       = ($urandom_range(0, 99) == 0);
            ex_valid    = ($urandom_range(0, 3) != 0);
            kind        = $urandom_range(0, 3);
            is_branch   = kind[0];
            is_jump     = kind[1];
            cmp_out     = is_branch ? 1'($urandom) : 1'bx;
            invert      = 1'($urandom);
            predicted_taken = 1'($urandom);
            pc          = $urandom & 32'hFFFF_FFFC;
            target      = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            fetch_ready = ($urandom_range(0, 2) == 0);
            tick();
            checks++;
            if ({redirect_valid, flush, ex_accept, misaligned_fault} !==
                    {m_rv, (m_rv || m_drain > 0), (!m_rv && m_drain == 0), m_fault} ||
                (m_rv && redirect_pc !== m_rpc) ||
                branch_count !== CW'(m_bc) || mispredict_count !== CW'(m_mc)) begin
                fails++;
                $display("FAIL random[%0d]: got rv/fl/acc/flt=%b rpc=%h bc=%0d mc=%0d want %b rpc=%h bc=%0d mc=%0d",
                         n, {redirect_valid, flush, ex_accept, misaligned_fault}, redirect_pc,
                         branch_count, mispredict_count,
                         {m_rv, (m_rv || m_drain > 0), (!m_rv && m_drain == 0), m_fault},
                         m_rpc, m_bc, m_mc);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        m_rv = 0; m_rpc = 32'd0; m_drain = 0; m_fault = 0; m_bc = 0; m_mc = 0;
        test_reset();
        test_beq_mispredict();
        test_bne_hold();
        test_correct_pred();
        test_misaligned();
        test_pc_wrap();
        test_saturation();
        test_reset_mid_redirect();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
